l1_dcache_wb: RTL and testbench

Parametrised write-back, write-allocate, set-associative L1 data cache with FIFO replacement. It sits between the core load/store port and main memory. Both sides use valid/ready handshakes; memory transfers are line bursts, one word per beat. It adds store support, dirty-line writeback and configurable geometry.

---
 rtl/l1_dcache_wb.sv | 213 +++++++++++++++++++++
 tb/tb_l1_dcache_wb.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_dcache_wb.sv
// Write-back, write-allocate, set-associative L1 data cache with FIFO replacement.
// Blocking core port; memory side moves whole lines as one-word-per-beat bursts.
module l1_dcache_wb #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int WAYS           = 4,
  parameter int SETS           = 16,
  parameter int WORDS_PER_LINE = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_hit,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W = $clog2(WAYS);
  localparam logic [OFF_W:0] LAST_BEAT = (OFF_W+1)'(WORDS_PER_LINE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WB_REQ, S_WB_DATA, S_FILL_REQ, S_FILL_DATA, S_INSTALL
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_write;
  logic [DATA_W-1:0]   r_wdata;
  logic [OFF_W:0]      r_beat;
  logic [WAY_W-1:0]    r_victim;
  logic [SETS-1:0]     r_valid [WAYS];
  logic [SETS-1:0]     r_dirty [WAYS];
  logic [WAY_W-1:0]    r_fifo  [SETS];
  logic [TAG_W-1:0]    r_tags  [WAYS][SETS];
  logic [DATA_W-1:0]   r_data  [WAYS][SETS][WORDS_PER_LINE];
  logic [DATA_W-1:0]   r_buf   [WORDS_PER_LINE];

  logic [TAG_W-1:0]    w_tag;
  logic [IDX_W-1:0]    w_idx;
  logic [OFF_W-1:0]    w_off;
  logic                w_hit;
  logic [WAY_W-1:0]    w_hit_way;
  logic                w_inv_found;
  logic [WAY_W-1:0]    w_inv_way;
  logic [WAY_W-1:0]    w_victim;
  logic                w_victim_dirty;

  assign w_tag = r_addr[ADDR_W-1 -: TAG_W];
  assign w_idx = r_addr[OFF_W +: IDX_W];
  assign w_off = r_addr[OFF_W-1:0];

  // Tag compare and victim choice: lowest invalid way first, else the set's FIFO pointer.
  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w][w_idx] && (r_tags[w][w_idx] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w][w_idx]) begin
        w_inv_found = 1'b1;
        w_inv_way   = WAY_W'(w);
      end
    end
    w_victim       = w_inv_found ? w_inv_way : r_fifo[w_idx];
    w_victim_dirty = r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= S_IDLE;
      r_beat   <= '0;
      r_victim <= '0;
      for (int w = 0; w < WAYS; w++) begin
        r_valid[w] <= '0;
        r_dirty[w] <= '0;
      end
      for (int s = 0; s < SETS; s++) r_fifo[s] <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) r_state <= S_LOOKUP;
        S_LOOKUP: begin
          if (w_hit) begin
            if (r_write) r_dirty[w_hit_way][w_idx] <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_victim <= w_victim;
            r_beat   <= '0;
            r_state  <= w_victim_dirty ? S_WB_REQ : S_FILL_REQ;
          end
        end
        S_WB_REQ: begin
          if (mem_req_ready) begin
            r_beat  <= '0;
            r_state <= S_WB_DATA;
          end
        end
        S_WB_DATA: begin
          if (mem_wready) begin
            if (r_beat == LAST_BEAT) begin
              r_beat  <= '0;
              r_state <= S_FILL_REQ;
            end else begin
              r_beat <= r_beat + (OFF_W+1)'(1);
            end
          end
        end
        S_FILL_REQ: begin
          if (mem_req_ready) begin
            r_beat  <= '0;
            r_state <= S_FILL_DATA;
          end
        end
        S_FILL_DATA: begin
          if (mem_rvalid) begin
            if (r_beat == LAST_BEAT) begin
              r_beat  <= '0;
              r_state <= S_INSTALL;
            end else begin
              r_beat <= r_beat + (OFF_W+1)'(1);
            end
          end
        end
        S_INSTALL: begin
          r_valid[r_victim][w_idx] <= 1'b1;
          r_dirty[r_victim][w_idx] <= r_write;
          r_fifo[w_idx]            <= r_fifo[w_idx] + WAY_W'(1);
          r_state                  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Arrays and request latches carry no reset; validity is tracked by the control bits above.
  always_ff @(posedge CLK) begin
    if (r_state == S_IDLE && req_valid) begin
      r_addr  <= req_addr;
      r_write <= req_write;
      r_wdata <= req_wdata;
    end
    if (r_state == S_LOOKUP && w_hit && r_write)
      r_data[w_hit_way][w_idx][w_off] <= r_wdata;
    if (r_state == S_FILL_DATA && mem_rvalid)
      r_buf[r_beat[OFF_W-1:0]] <= mem_rdata;
    if (r_state == S_INSTALL) begin
      r_tags[r_victim][w_idx] <= w_tag;
      for (int k = 0; k < WORDS_PER_LINE; k++)
        r_data[r_victim][w_idx][k] <= (r_write && (OFF_W'(k) == w_off)) ? r_wdata : r_buf[k];
    end
  end

  always_comb begin
    req_ready     = (r_state == S_IDLE);
    resp_valid    = 1'b0;
    resp_hit      = 1'b0;
    resp_rdata    = '0;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_req_addr  = '0;
    mem_wvalid    = 1'b0;
    mem_wdata     = '0;
    case (r_state)
      S_LOOKUP: begin
        if (w_hit) begin
          resp_valid = 1'b1;
          resp_hit   = 1'b1;
          resp_rdata = r_write ? r_wdata : r_data[w_hit_way][w_idx][w_off];
        end
      end
      S_WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {r_tags[r_victim][w_idx], w_idx, {OFF_W{1'b0}}};
      end
      S_WB_DATA: begin
        mem_wvalid = 1'b1;
        mem_wdata  = r_data[r_victim][w_idx][r_beat[OFF_W-1:0]];
      end
      S_FILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {w_tag, w_idx, {OFF_W{1'b0}}};
      end
      S_INSTALL: begin
        resp_valid = 1'b1;
        resp_rdata = r_write ? r_wdata : r_buf[w_off];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_l1_dcache_wb.sv
// Directed bench for l1_dcache_wb: response scoreboard plus a behavioural line-burst memory.
module tb_l1_dcache_wb #(
  parameter int WAYS = 4,
  parameter int SETS = 16,
  parameter int WPL  = 8
);
  localparam int OFF_W = $clog2(WPL);
  localparam int IDX_W = $clog2(SETS);

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        req_valid, req_write, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_hit;
  logic [31:0] resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_write;
  logic [31:0] mem_req_addr;
  logic        mem_wvalid, mem_wready;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  l1_dcache_wb #(.ADDR_W(32), .DATA_W(32), .WAYS(WAYS), .SETS(SETS), .WORDS_PER_LINE(WPL)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  typedef struct packed { logic [31:0] d; logic h; } exp_t;
  typedef struct packed { logic w; logic [31:0] a; } mreq_t;

  exp_t        exp_q[$];
  mreq_t       mreq_log[$];
  logic [31:0] wb_log[$];
  logic [31:0] refmem [logic [31:0]];
  logic [31:0] memarr [logic [31:0]];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int resp_cyc = 0;
  int resp_cnt = 0;
  int fill_beat = -1;
  int cfg_stall = 0;
  bit cfg_alt = 1'b0;
  bit abort;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] mk(int t, int i, int o);
    return 32'((t << (OFF_W + IDX_W)) | (i << OFF_W) | o);
  endfunction

  localparam logic [31:0] L1A = 32'(2 << OFF_W);

  // Default memory contents: low byte 0xA0+offset, upper bits distinguish lines.
  function automatic logic [31:0] pat(logic [31:0] a);
    logic [31:0] ln;
    ln = (a >> OFF_W) ^ (L1A >> OFF_W);
    return (ln << 8) | (32'hA0 + (a & 32'(WPL - 1)));
  endfunction

  function automatic logic [31:0] exp_rd(logic [31:0] a);
    return refmem.exists(a) ? refmem[a] : pat(a);
  endfunction

  function automatic logic [31:0] mem_rd(logic [31:0] a);
    return memarr.exists(a) ? memarr[a] : pat(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RST_N === 1'b1 && resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("resp_spurious", 32'(resp_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_rdata", resp_rdata, e.d);
        check("resp_hit", 32'(resp_hit), 32'(e.h));
      end
      resp_cyc = cyc;
      resp_cnt++;
    end
  end

  // Memory model: optional request stall, optional wready gap on odd beats, back-to-back fill beats.
  initial begin
    logic [31:0] ra, d;
    logic rw;
    mem_req_ready = 1'b0; mem_wready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge CLK);
      if (RST_N === 1'b1 && mem_req_valid === 1'b1) begin
        abort = 1'b0;
        ra = mem_req_addr;
        rw = mem_req_write;
        mreq_log.push_back('{w: rw, a: ra});
        for (int s = 0; s < cfg_stall && !abort; s++) begin
          @(negedge CLK);
          if (!RST_N) abort = 1'b1;
          else begin
            check("req_valid_held", 32'(mem_req_valid), 32'd1);
            check("req_addr_held", mem_req_addr, ra);
          end
        end
        if (!abort) begin
          mem_req_ready = 1'b1;
          @(negedge CLK);
          mem_req_ready = 1'b0;
          if (!RST_N) abort = 1'b1;
        end
        if (rw) begin
          for (int b = 0; b < WPL && !abort; b++) begin
            if (cfg_alt && (b % 2) == 1) begin
              d = mem_wdata;
              @(negedge CLK);
              if (!RST_N) abort = 1'b1;
              else check("wdata_held", mem_wdata, d);
            end
            if (!abort) begin
              check("wvalid", 32'(mem_wvalid), 32'd1);
              wb_log.push_back(mem_wdata);
              memarr[32'(ra + 32'(b))] = mem_wdata;
              mem_wready = 1'b1;
              @(negedge CLK);
              mem_wready = 1'b0;
              if (!RST_N) abort = 1'b1;
            end
          end
        end else begin
          for (int b = 0; b < WPL && !abort; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_rd(32'(ra + 32'(b)));
            fill_beat  = b;
            @(negedge CLK);
            if (!RST_N) abort = 1'b1;
          end
          mem_rvalid = 1'b0;
        end
      end
    end
  end

  task automatic launch(input bit w, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge CLK);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    while (!req_ready && n < 500) begin
      @(negedge CLK);
      n++;
    end
    check("accept_timeout", 32'(req_ready), 32'd1);
    acc_cyc = cyc;
    @(negedge CLK);
    req_valid = 1'b0;
    check("ready_low_after_accept", 32'(req_ready), 32'd0);
  endtask

  task automatic do_req(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_d, input bit exp_hit);
    int start, n;
    start = resp_cnt;
    n = 0;
    exp_q.push_back('{d: exp_d, h: exp_hit});
    if (w) refmem[a] = d;
    launch(w, a, d);
    while (resp_cnt == start && n < 500) begin
      @(posedge CLK);
      n++;
    end
    check("resp_timeout", 32'(resp_cnt != start), 32'd1);
    if (exp_hit) check("hit_latency", 32'(resp_cyc - acc_cyc), 32'd1);
  endtask

  initial begin
    int n0, w0, n;
    RST_N = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge CLK);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_mem_wvalid", 32'(mem_wvalid), 32'd0);
    check("rst_mem_req_addr", mem_req_addr, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Cold miss then hit on the same word
    n0 = mreq_log.size();
    do_req(1'b0, mk(0, 2, 3), 32'd0, 32'h0000_00A3, 1'b0);
    check("t1_fill_count", 32'(mreq_log.size() - n0), 32'd1);
    check("t1_fill_write", 32'(mreq_log[n0].w), 32'd0);
    check("t1_fill_addr", mreq_log[n0].a, L1A);
    do_req(1'b0, mk(0, 2, 3), 32'd0, 32'h0000_00A3, 1'b1);
    check("t1_hit_no_mem", 32'(mreq_log.size() - n0), 32'd1);

    // Store hit then load back
    n0 = mreq_log.size();
    do_req(1'b1, mk(0, 2, WPL/2), 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    do_req(1'b0, mk(0, 2, WPL/2), 32'd0, 32'hDEAD_BEEF, 1'b1);
    check("t2_no_mem", 32'(mreq_log.size() - n0), 32'd0);

    // Fill remaining ways of set 2, then evict the dirty way 0
    for (int t = 1; t < WAYS; t++) begin
      n0 = mreq_log.size();
      do_req(1'b0, mk(t, 2, 0), 32'd0, pat(mk(t, 2, 0)), 1'b0);
      check("t3_fill_count", 32'(mreq_log.size() - n0), 32'd1);
      check("t3_fill_addr", mreq_log[n0].a, mk(t, 2, 0));
    end
    n0 = mreq_log.size();
    w0 = wb_log.size();
    do_req(1'b0, mk(WAYS, 2, 1), 32'd0, pat(mk(WAYS, 2, 1)), 1'b0);
    check("t3_req_count", 32'(mreq_log.size() - n0), 32'd2);
    check("t3_wb_first", 32'(mreq_log[n0].w), 32'd1);
    check("t3_wb_addr", mreq_log[n0].a, L1A);
    check("t3_fill_write", 32'(mreq_log[n0+1].w), 32'd0);
    check("t3_fill_addr", mreq_log[n0+1].a, mk(WAYS, 2, 0));
    check("t3_wb_beats", 32'(wb_log.size() - w0), 32'(WPL));
    for (int b = 0; b < WPL; b++) check("t3_wb_data", wb_log[w0+b], exp_rd(32'(L1A + 32'(b))));
    check("t3_wb_dead", wb_log[w0 + WPL/2], 32'hDEAD_BEEF);

    // Stalled request handshakes and gapped writeback beats
    do_req(1'b1, mk(1, 2, 1), 32'h1234_5678, 32'h1234_5678, 1'b1);
    cfg_stall = 5;
    cfg_alt   = 1'b1;
    n0 = mreq_log.size();
    w0 = wb_log.size();
    do_req(1'b0, mk(WAYS+1, 2, 2), 32'd0, pat(mk(WAYS+1, 2, 2)), 1'b0);
    cfg_stall = 0;
    cfg_alt   = 1'b0;
    check("t4_req_count", 32'(mreq_log.size() - n0), 32'd2);
    check("t4_wb_addr", mreq_log[n0].a, mk(1, 2, 0));
    check("t4_wb_beats", 32'(wb_log.size() - w0), 32'(WPL));
    for (int b = 0; b < WPL; b++) check("t4_wb_data", wb_log[w0+b], exp_rd(mk(1, 2, b)));

    // Reset in the middle of a fill burst
    n0 = mreq_log.size();
    fill_beat = -1;
    launch(1'b0, mk(WAYS+2, 3, 1), 32'd0);
    n = 0;
    while (fill_beat != 3 && n < 500) begin
      @(posedge CLK);
      n++;
    end
    check("t5_reached_beat3", 32'(fill_beat), 32'd3);
    #1 RST_N = 1'b0;
    #1;
    check("t5_rst_req_ready", 32'(req_ready), 32'd1);
    check("t5_rst_resp_valid", 32'(resp_valid), 32'd0);
    check("t5_rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("t5_rst_mem_wvalid", 32'(mem_wvalid), 32'd0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    do_req(1'b0, mk(WAYS+2, 3, 1), 32'd0, pat(mk(WAYS+2, 3, 1)), 1'b0);
    check("t5_refill_count", 32'(mreq_log.size() - n0), 32'd2);
    do_req(1'b0, mk(0, 2, 3), 32'd0, 32'h0000_00A3, 1'b0);

    repeat (3) @(negedge CLK);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
